// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels up to NREQ internal requesters onto one
// APB4 master port, with SETUP/ACCESS sequencing and a stuck-slave timeout.
module apb_req_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              preset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*4-1:0] req_strb,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    output logic [3:0]        pstrb,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned PW = (NREQ > 2) ? 2 : 1;
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]    state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_q;
    logic [CW-1:0] cnt_q;

    logic [PW-1:0] arb_base;
    logic [PW-1:0] arb_idx;
    logic [PW-1:0] cand;
    logic          arb_found;
    logic          finish_ok;
    logic          timeout_hit;
    logic          accept;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[PW-1:0];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search; on a completing ACCESS the base is already the advanced pointer
    always_comb begin
        arb_base  = (state_q == ST_ACCESS) ? wrap_add(gnt_q, 1) : ptr_q;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = wrap_add(arb_base, i);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Completion, timeout and acceptance qualifiers
    always_comb begin
        finish_ok   = (state_q == ST_ACCESS) && pready;
        // Abort on the ACCESS cycle that would bring the wait count up to TIMEOUT
        timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready &&
                      ((32'(cnt_q) + 32'd1) == TIMEOUT);
        accept      = arb_found && ((state_q == ST_IDLE) || finish_ok);
    end

    // APB sequencing, response capture and grant bookkeeping
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;

            case (state_q)
                ST_IDLE: ;
                ST_SETUP: begin
                    penable <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready || timeout_hit) begin
                        rsp_valid <= onehot(gnt_q);
                        rsp_err   <= pready ? pslverr : 1'b1;
                        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                        ptr_q     <= wrap_add(gnt_q, 1);
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A new grant (from IDLE or chained onto a completion) overrides the
            // return-to-IDLE values above, keeping psel high for back-to-back
            if (accept) begin
                req_ready <= onehot(arb_idx);
                gnt_q     <= arb_idx;
                psel      <= 1'b1;
                penable   <= 1'b0;
                pwrite    <= req_write[arb_idx];
                paddr     <= req_addr[32'(arb_idx)*AW +: AW];
                pwdata    <= req_write[arb_idx] ? req_wdata[32'(arb_idx)*DW +: DW] : '0;
                pstrb     <= req_write[arb_idx] ? req_strb[32'(arb_idx)*4 +: 4] : 4'h0;
                state_q   <= ST_SETUP;
            end
        end
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Sits between internal requesters and the UART APB slave port.
- Arbitrates up to NREQ requesters round-robin and drives a single APB4 master interface.
- Sequences SETUP and ACCESS phases, waits on pready, and returns response/error to the granted requester.
- Bounds a stuck slave with a timeout.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 12, APB address width.
- DW, 32, APB data width.
- TIMEOUT, 255, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- preset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request pending.
- req_ready  out  NREQ  one-hot, 1-cycle pulse when a request is accepted.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_strb  in  NREQ*4  packed byte strobes.
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse on completion.
- rsp_rdata  out  DW  read data, valid while rsp_valid is high.
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- pstrb  out  4  APB strobes.
- prdata  in  DW  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Output style: all outputs registered. Reset (async, preset=1) clears every output to 0, state to IDLE, round-robin pointer to 0, and the timeout counter to 0.
- State machine: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set: grant = first set bit searching from pointer upward, with wrap-around.
  - Pulse req_ready[grant] and latch the write/addr/wdata/strb of the granted requester.
  - Next state SETUP, with psel=1 and penable=0 on the next cycle.
- SETUP: exactly 1 cycle. Next state ACCESS with penable=1 and the counter cleared.
- ACCESS:
  - Hold psel=1, penable=1. pwrite, paddr, pwdata and pstrb stay stable from SETUP until completion.
  - Increment the counter every cycle pready=0.
- Completion on pready=1:
  - Pulse rsp_valid[grant].
  - rsp_rdata = prdata on reads, 0 on writes.
  - rsp_err = pslverr.
  - pointer = grant+1, modulo NREQ.
- Timeout (TIMEOUT!=0, counter==TIMEOUT, pready still 0):
  - Complete with rsp_err=1 and rsp_rdata=0.
  - Deassert psel and penable.
- Back-to-back transfers:
  - If any req_valid is set in the completion cycle, arbitrate using the updated pointer, pulse req_ready, and go straight to SETUP.
  - psel stays 1, penable drops to 0, and the new address/data are presented.
  - Otherwise return to IDLE with psel=0 and penable=0.
- Read data rules: on reads pwdata=0 and pstrb=0 (APB4). On writes pstrb = the latched strb.
- No pready double-count: penable always falls in the cycle after the pready sample.
- Ordering and fairness:
  - rsp_valid for a grant never precedes its req_ready and never overlaps it for the same requester.
  - A requester dropping req_valid after being accepted has no effect on the transfer in flight.
  - Requests arriving mid-transfer wait; no preemption.
  - With all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
- Reset mid-transfer: psel, penable, rsp_valid and req_ready drop immediately (async). The in-flight transfer is discarded with no response.
- Minimum latency: req_valid in IDLE to rsp_valid with zero-wait pready is 3 cycles (accept, SETUP, ACCESS).

Test Plan:
- Single write: req0 write, addr 0x004, data 0xA5A5_0001, strb 0xF, pready=1.
  - Required: psel rises on cycle 1, penable on cycle 2, rsp_valid[0] on cycle 3, rsp_err=0.
  - Required: paddr and pwdata stable throughout.
- Read with 3 wait states: req1 read, addr 0x010, prdata=0x0000_0055, pready low for 3 cycles.
  - Required: rsp_valid[1] with rsp_rdata=0x55.
  - Required: pwdata=0 and pstrb=0 during the transfer.
- Contention fairness: req0 and req1 held valid for 6 transfers.
  - Required: grant order 0,1,0,1,0,1.
  - Required: psel stays high between transfers and penable toggles 0/1.
- Slave error: pslverr=1 with pready=1 on a write.
  - Required: rsp_err=1 for that requester only.
  - Required: the next transfer returns rsp_err=0.
- Timeout: TIMEOUT=4, pready held 0.
  - Required: after 4 ACCESS cycles, rsp_valid with rsp_err=1 and rsp_rdata=0.
  - Required: psel and penable are 0 on the following cycle.
- Reset mid-ACCESS: assert preset during wait states.
  - Required: all outputs 0 asynchronously and no rsp_valid.
  - Required: after release, the first grant goes to the lowest valid requester.
